// File: rtl/threshold_hold.sv
// Threshold alarm with N-capture confirmation and a timed release hold.
// Each capture is taken on the falling edge of the upstream DONE strobe.
module threshold_hold #(
  parameter int WIDTH       = 24,
  parameter int CONFIRM     = 3,
  parameter int HOLD_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] VALUE,
  input  logic             DONE_IN,
  input  logic [WIDTH-1:0] TH_HI,
  input  logic [WIDTH-1:0] TH_LO,
  input  logic             CLEAR,
  output logic             ALARM,
  output logic             ALARM_PULSE,
  output logic             HOLD_ACTIVE,
  output logic             CFG_ERR,
  output logic [WIDTH-1:0] LAST_VAL,
  output logic [15:0]      EVENT_COUNT
);

  // state   | meaning
  // S_IDLE  | no alarm, waiting for an above-threshold capture
  // S_ARMING| counting consecutive above-threshold captures
  // S_ALARM | alarm asserted
  // S_HOLD  | value fell below TH_LO, alarm held while timer runs
  typedef enum logic [1:0] {S_IDLE, S_ARMING, S_ALARM, S_HOLD} state_t;

  localparam logic [3:0]  CONFIRM_W = 4'(CONFIRM);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] timer, timer_nxt;
  logic        pulse_nxt;
  logic        done_q;
  logic        cap, above, below;

  always_comb begin
    cap       = done_q & ~DONE_IN;
    above     = (VALUE >= TH_HI);
    below     = (VALUE < TH_LO);
    state_nxt = state;
    cnt_nxt   = cnt;
    timer_nxt = timer;
    pulse_nxt = 1'b0;

    if (CLEAR || CFG_ERR) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 4'd0;
      timer_nxt = 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cap && above) begin
            cnt_nxt = 4'd1;
            if (CONFIRM_W == 4'd1) begin
              state_nxt = S_ALARM;
              pulse_nxt = 1'b1;
            end else begin
              state_nxt = S_ARMING;
            end
          end
        end
        S_ARMING: begin
          if (cap) begin
            if (above) begin
              cnt_nxt = cnt + 4'd1;
              if (cnt + 4'd1 == CONFIRM_W) begin
                state_nxt = S_ALARM;
                pulse_nxt = 1'b1;
              end
            end else begin
              state_nxt = S_IDLE;
              cnt_nxt   = 4'd0;
            end
          end
        end
        S_ALARM: begin
          if (cap && below) begin
            state_nxt = S_HOLD;
            timer_nxt = HOLD_LOAD;
          end
        end
        S_HOLD: begin
          // a fresh trip during hold resumes the same event, so no pulse
          if (cap && above) begin
            state_nxt = S_ALARM;
            timer_nxt = 16'd0;
          end else if (timer == 16'd0) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
          end else begin
            timer_nxt = timer - 16'd1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
          timer_nxt = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      timer       <= 16'd0;
      done_q      <= 1'b0;
      ALARM       <= 1'b0;
      ALARM_PULSE <= 1'b0;
      HOLD_ACTIVE <= 1'b0;
      CFG_ERR     <= 1'b0;
      LAST_VAL    <= '0;
      EVENT_COUNT <= 16'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      timer       <= timer_nxt;
      done_q      <= DONE_IN;
      ALARM       <= (state_nxt == S_ALARM) || (state_nxt == S_HOLD);
      ALARM_PULSE <= pulse_nxt;
      HOLD_ACTIVE <= (state_nxt == S_HOLD);
      CFG_ERR     <= (TH_LO > TH_HI);
      if (cap)
        LAST_VAL <= VALUE;
      if (pulse_nxt && (EVENT_COUNT != 16'hFFFF))
        EVENT_COUNT <= EVENT_COUNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_threshold_hold.sv
// Directed bench for threshold_hold: a behavioural model checked every cycle
// plus hand-computed literal expectations at key points.
module tb_threshold_hold;
  localparam int W  = 24;
  localparam int CF = 3;
  localparam int HC = 16;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [W-1:0]  VALUE = '0;
  logic          DONE_IN = 1'b0;
  logic [W-1:0]  TH_HI = 24'd1000;
  logic [W-1:0]  TH_LO = 24'd900;
  logic          CLEAR = 1'b0;
  logic          ALARM, ALARM_PULSE, HOLD_ACTIVE, CFG_ERR;
  logic [W-1:0]  LAST_VAL;
  logic [15:0]   EVENT_COUNT;

  threshold_hold #(.WIDTH(W), .CONFIRM(CF), .HOLD_CYCLES(HC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .VALUE(VALUE), .DONE_IN(DONE_IN),
    .TH_HI(TH_HI), .TH_LO(TH_LO), .CLEAR(CLEAR),
    .ALARM(ALARM), .ALARM_PULSE(ALARM_PULSE), .HOLD_ACTIVE(HOLD_ACTIVE),
    .CFG_ERR(CFG_ERR), .LAST_VAL(LAST_VAL), .EVENT_COUNT(EVENT_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: run = consecutive above captures, hold_left = hold cycles remaining
  bit      started = 0;
  bit      m_done_q, m_alarm, m_pulse, m_cfg;
  int      m_run, m_hold_left, m_events;
  longint  m_last;

  always @(posedge CLK) begin
    bit c, ab, bl;
    if (!RESET_N) begin
      started = 1; m_done_q = 0; m_alarm = 0; m_pulse = 0; m_cfg = 0;
      m_run = 0; m_hold_left = 0; m_events = 0; m_last = 0;
    end else begin
      c  = m_done_q && !DONE_IN;
      ab = VALUE >= TH_HI;
      bl = VALUE < TH_LO;
      m_done_q = DONE_IN;
      if (c) m_last = VALUE;
      m_pulse = 0;
      if (CLEAR || m_cfg) begin
        m_alarm = 0; m_hold_left = 0; m_run = 0;
      end else if (m_alarm && m_hold_left > 0) begin
        if (c && ab) m_hold_left = 0;
        else begin
          m_hold_left--;
          if (m_hold_left == 0) m_alarm = 0;
        end
      end else if (m_alarm) begin
        if (c && bl) m_hold_left = HC;
      end else if (c) begin
        if (ab) begin
          m_run++;
          if (m_run >= CF) begin m_alarm = 1; m_pulse = 1; m_run = 0; end
        end else m_run = 0;
      end
      if (m_pulse && m_events < 65535) m_events++;
      m_cfg = TH_LO > TH_HI;
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("alarm",       ALARM,       m_alarm);
      chk("alarm_pulse", ALARM_PULSE, m_pulse);
      chk("hold_active", HOLD_ACTIVE, m_alarm && m_hold_left > 0);
      chk("cfg_err",     CFG_ERR,     m_cfg);
      chk("last_val",    LAST_VAL,    m_last);
      chk("event_count", EVENT_COUNT, m_events);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic do_cap(input int v, input bit clr = 0);
    DONE_IN = 1; step();
    DONE_IN = 0; VALUE = W'(v); CLEAR = clr; step();
    CLEAR = 0;
  endtask

  initial begin
    RESET_N = 0; step(2);
    chk("reset_alarm", ALARM, 0);
    chk("reset_evcnt", EVENT_COUNT, 0);
    RESET_N = 1; step();

    // three caps above TH_HI trip the alarm
    do_cap(1200); do_cap(1200);
    chk("s1_no_alarm_yet", ALARM, 0);
    do_cap(1200);
    chk("s1_alarm", ALARM, 1);
    chk("s1_pulse", ALARM_PULSE, 1);
    chk("s1_events", EVENT_COUNT, 1);
    step();
    chk("s1_pulse_drop", ALARM_PULSE, 0);

    // release: 16 held cycles then idle
    do_cap(800);
    chk("s2_hold", HOLD_ACTIVE, 1);
    step(15);
    chk("s2_still_alarm", ALARM, 1);
    step();
    chk("s2_released", ALARM, 0);
    chk("s2_hold_off", HOLD_ACTIVE, 0);

    // in-band capture restarts the confirm count
    do_cap(1200); do_cap(1200); do_cap(950); do_cap(1200);
    chk("s3_no_alarm", ALARM, 0);
    do_cap(1200);
    chk("s3_no_alarm2", ALARM, 0);
    do_cap(1200);
    chk("s3_alarm", ALARM, 1);
    chk("s3_events", EVENT_COUNT, 2);

    // trip during hold at timer=5 resumes alarm without a new event
    do_cap(800);
    step(9);
    do_cap(1500);
    chk("s4_alarm", ALARM, 1);
    chk("s4_no_pulse", ALARM_PULSE, 0);
    chk("s4_hold_off", HOLD_ACTIVE, 0);
    chk("s4_events", EVENT_COUNT, 2);

    // threshold equality: ==TH_LO is in-band, ==TH_HI is above
    do_cap(900);
    chk("s5_eq_lo_inband", HOLD_ACTIVE, 0);
    do_cap(899);
    chk("s5_below_lo", HOLD_ACTIVE, 1);
    step(20);
    do_cap(1000); do_cap(1000); do_cap(1000);
    chk("s5_eq_hi_alarm", ALARM, 1);
    chk("s5_events", EVENT_COUNT, 3);
    do_cap(0); step(20);

    // CLEAR on the third confirming capture wins
    do_cap(1200); do_cap(1200); do_cap(1200, 1);
    chk("s6_clear_alarm", ALARM, 0);
    chk("s6_clear_pulse", ALARM_PULSE, 0);
    chk("s6_clear_last", LAST_VAL, 1200);
    do_cap(1200); do_cap(1200);
    chk("s6_restart", ALARM, 0);
    do_cap(1200);
    chk("s6_alarm", ALARM, 1);
    chk("s6_events", EVENT_COUNT, 4);

    // reset during HOLD beats CLEAR and a simultaneous capture
    do_cap(800); step(3);
    chk("s7_in_hold", HOLD_ACTIVE, 1);
    DONE_IN = 1; step();
    RESET_N = 0; DONE_IN = 0; CLEAR = 1; VALUE = 24'd1500; step();
    CLEAR = 0;
    chk("s7_rst_alarm", ALARM, 0);
    chk("s7_rst_hold", HOLD_ACTIVE, 0);
    chk("s7_rst_events", EVENT_COUNT, 0);
    chk("s7_rst_last", LAST_VAL, 0);
    DONE_IN = 1; step();
    RESET_N = 1; DONE_IN = 0; VALUE = 24'd3000; step();
    chk("s7_no_post_rst_cap", LAST_VAL, 0);
    step();

    // inverted thresholds block alarms but still capture
    TH_LO = 24'd1100; step();
    chk("s8_cfg_err", CFG_ERR, 1);
    do_cap(2000); do_cap(2000); do_cap(2000); do_cap(2000);
    chk("s8_no_alarm", ALARM, 0);
    chk("s8_last", LAST_VAL, 2000);
    chk("s8_events", EVENT_COUNT, 0);
    TH_LO = 24'd900; step(2);
    chk("s8_cfg_ok", CFG_ERR, 0);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
